// File: rtl/sw_debounce_if.sv
// Switch bus between the board pins and the operand/select mux stage.
// The raw switch levels flow in; debounced levels and edge pulses flow out.
interface sw_debounce_if #(
    parameter int unsigned WIDTH = 7
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // Board side: drives raw switches, consumes debounced results.
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchronizer plus stability counter for slide switches.
// A bit's debounced level follows the synchronized input only after the new
// level has been seen for CNT_MAX consecutive cycles; any cycle back at the
// old level restarts the count. Registered rise/fall pulses and an aggregate
// change strobe accompany every debounced transition.
module sw_debounce #(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned CNT_MAX = 1000000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    sw_debounce_if.slave sw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;
    logic             changed_q, changed_d;

    // Two-flop synchronizer on the asynchronous switch levels; no logic between flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw.sw_raw;
            s2_q <= s1_q;
        end
    end

    // Per-bit stability count; commits the new level once the count is exhausted.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        changed_d = (|rise_d) | (|fall_d);
    end

    // Counter, debounced level and edge pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw.sw_stable  = stable_q;
    assign sw.sw_rise    = rise_q;
    assign sw.sw_fall    = fall_q;
    assign sw.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with CNT_MAX=4, WIDTH=7.
module tb_sw_debounce;

    localparam int unsigned W  = 7;
    localparam int unsigned CM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH  (W),
        .CNT_MAX(CM),
        .CNT_W  (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: the debouncer sees the raw level from two edges ago;
    // a bit flips once that level has differed from the debounced level for
    // CM consecutive edges, and the run restarts after every flip.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_stable, m_rise, m_fall;
    logic         m_chg;
    int unsigned  run [W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
            hist = {};
            hist.push_front('0);
            hist.push_front('0);
        end else begin
            logic [W-1:0] seen;
            seen   = hist[1];
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[i] != m_stable[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == CM) begin
                        m_stable[i] = seen[i];
                        if (seen[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_chg = (m_rise != 0) || (m_fall != 0);
            hist.push_front(bus.sw_raw);
            void'(hist.pop_back());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [W-1:0] lvl);
        bus.sw_raw = lvl;
        repeat (CM + 6) step();
    endtask

    task automatic test_reset();
        bus.sw_raw = 7'h7F;
        rst_n = 1'b0;
        repeat (3) step();
        n_total++;
        if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== '0)
            $display("FAIL reset_outputs: got stable=%h rise=%h fall=%h chg=%b expected all 0",
                     bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e <= 5) begin
                n_total++;
                if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0)
                    $display("FAIL reset_early e=%0d: got stable=%h chg=%b expected 00/0",
                             e, bus.sw_stable, bus.sw_changed);
                else n_pass++;
            end else if (e == 6) begin
                n_total++;
                if (bus.sw_stable !== 7'h7F || bus.sw_rise !== 7'h7F ||
                    bus.sw_fall !== 7'h00 || bus.sw_changed !== 1'b1)
                    $display("FAIL reset_rise: got stable=%h rise=%h fall=%h chg=%b expected 7f/7f/00/1",
                             bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
                else n_pass++;
            end else begin
                n_total++;
                if (bus.sw_stable !== 7'h7F || bus.sw_rise !== 7'h00 || bus.sw_changed !== 1'b0)
                    $display("FAIL reset_pulse_end: got stable=%h rise=%h chg=%b expected 7f/00/0",
                             bus.sw_stable, bus.sw_rise, bus.sw_changed);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clean();
        settle(7'h00);
        bus.sw_raw = 7'h40;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e <= 5) begin
                n_total++;
                if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0)
                    $display("FAIL clean_early e=%0d: got stable=%h chg=%b expected 00/0",
                             e, bus.sw_stable, bus.sw_changed);
                else n_pass++;
            end else if (e == 6) begin
                n_total++;
                if (bus.sw_stable !== 7'h40 || bus.sw_rise !== 7'h40 ||
                    bus.sw_fall !== 7'h00 || bus.sw_changed !== 1'b1)
                    $display("FAIL clean_rise: got stable=%h rise=%h fall=%h chg=%b expected 40/40/00/1",
                             bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
                else n_pass++;
            end else begin
                n_total++;
                if (bus.sw_stable !== 7'h40 || bus.sw_rise !== 7'h00 || bus.sw_changed !== 1'b0)
                    $display("FAIL clean_pulse_end: got stable=%h rise=%h chg=%b expected 40/00/0",
                             bus.sw_stable, bus.sw_rise, bus.sw_changed);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        settle(7'h00);
        for (int r = 0; r < 5; r++) begin
            bus.sw_raw = 7'h01;
            repeat (3) begin
                step();
                if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0) bad++;
            end
            bus.sw_raw = 7'h00;
            repeat (3) begin
                step();
                if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0) bad++;
            end
        end
        repeat (CM + 4) begin
            step();
            if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0)
            $display("FAIL bounce_reject: got %0d cycles with stable/changed activity, expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_settle();
        int pulses = 0;
        int rise_at = -1;
        settle(7'h00);
        for (int r = 0; r < 4; r++) begin
            bus.sw_raw = 7'h08; step();
            if (bus.sw_rise[3]) pulses++;
            bus.sw_raw = 7'h00; step();
            if (bus.sw_rise[3]) pulses++;
        end
        bus.sw_raw = 7'h08;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (bus.sw_rise[3]) begin
                pulses++;
                if (rise_at < 0) rise_at = e;
            end
        end
        n_total++;
        if (rise_at !== 6)
            $display("FAIL settle_latency: got rise at edge %0d after final sample, expected 6", rise_at);
        else n_pass++;
        n_total++;
        if (pulses !== 1)
            $display("FAIL settle_pulse_count: got %0d rise pulses, expected 1", pulses);
        else n_pass++;
        n_total++;
        if (bus.sw_stable !== 7'h08)
            $display("FAIL settle_level: got stable=%h expected 08", bus.sw_stable);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int chg_cycles = 0;
        settle(7'h41);
        n_total++;
        if (bus.sw_stable !== 7'h41)
            $display("FAIL simul_setup: got stable=%h expected 41", bus.sw_stable);
        else n_pass++;
        bus.sw_raw = 7'h06;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (bus.sw_changed) chg_cycles++;
            if (e == 6) begin
                n_total++;
                if (bus.sw_stable !== 7'h06 || bus.sw_rise !== 7'h06 ||
                    bus.sw_fall !== 7'h41 || bus.sw_changed !== 1'b1)
                    $display("FAIL simul_edge: got stable=%h rise=%h fall=%h chg=%b expected 06/06/41/1",
                             bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
                else n_pass++;
            end
        end
        n_total++;
        if (chg_cycles !== 1)
            $display("FAIL simul_changed_count: got %0d changed cycles, expected 1", chg_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        settle(7'h00);
        bus.sw_raw = 7'h04;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== '0)
            $display("FAIL midreset_outputs: got stable=%h chg=%b expected 00/0",
                     bus.sw_stable, bus.sw_changed);
        else n_pass++;
        repeat (2) step();
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e <= 5) begin
                n_total++;
                if (bus.sw_stable !== 7'h00 || bus.sw_changed !== 1'b0)
                    $display("FAIL midreset_early e=%0d: got stable=%h chg=%b expected 00/0",
                             e, bus.sw_stable, bus.sw_changed);
                else n_pass++;
            end else begin
                n_total++;
                if (bus.sw_stable !== 7'h04 || bus.sw_rise !== 7'h04 || bus.sw_changed !== 1'b1)
                    $display("FAIL midreset_rise: got stable=%h rise=%h chg=%b expected 04/04/1",
                             bus.sw_stable, bus.sw_rise, bus.sw_changed);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] lvl;
        lvl = bus.sw_raw;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 7) == 0) lvl[i] = ~lvl[i];
            bus.sw_raw = lvl;
            step();
            n_total++;
            if (bus.sw_stable !== m_stable || bus.sw_rise !== m_rise ||
                bus.sw_fall !== m_fall || bus.sw_changed !== m_chg)
                $display("FAIL random c=%0d: got stable=%h rise=%h fall=%h chg=%b expected %h/%h/%h/%b",
                         c, bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                         m_stable, m_rise, m_fall, m_chg);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_settle();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
